dram_arbiter: RTL and testbench

DRAM_ARBITER -- requirements
Module: dram_arbiter

---
 rtl/dram_arbiter.sv | 127 ++++++++++++
 tb/tb_dram_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - four-requester round-robin arbiter in front of a single-port DRAM.
// A grant latches the request; the DRAM strobes then follow the latched copy until the ack.
module dram_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_req,
  input  logic [3:0]  i_we,
  input  logic [63:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_ack,
  output logic [7:0]  o_rdata,
  output logic [3:0]  o_grant,
  output logic        o_busy,
  output logic [15:0] o_dram_addr,
  output logic        o_dram_read,
  output logic        o_dram_write,
  output logic [7:0]  o_dram_out,
  input  logic [7:0]  i_dram_in
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, DONE} state_t;

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  gidx_q, gidx_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;

  logic        found;
  logic [1:0]  win;
  logic [1:0]  cand;

  // Upward search from the priority pointer; 2-bit arithmetic gives the 3->0 wrap.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    cand  = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && i_req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ACCESS;
          gidx_d  = win;
          ptr_d   = win + 2'd1;
          we_d    = i_we[win];
          addr_d  = i_addr[{win, 4'b0000} +: 16];
          wdata_d = i_wdata[{win, 3'b000} +: 8];
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          state_d = RDWAIT;
          cnt_d   = CNT_INIT;
        end
      end
      RDWAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = DONE;
          rdata_d = i_dram_in;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      gidx_q  <= 2'd0;
      cnt_q   <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= 16'd0;
      wdata_q <= 8'd0;
      rdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode straight from registered state so reset clears them without an edge.
  assign o_busy       = (state_q != IDLE);
  assign o_grant      = o_busy ? (4'b0001 << gidx_q) : 4'b0000;
  assign o_ack        = (state_q == DONE) ? (4'b0001 << gidx_q) : 4'b0000;
  assign o_dram_write = (state_q == ACCESS) && we_q;
  assign o_dram_read  = ((state_q == ACCESS) && !we_q) || (state_q == RDWAIT);
  assign o_dram_addr  = addr_q;
  assign o_dram_out   = wdata_q;
  assign o_rdata      = rdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - self-checking bench for dram_arbiter with a transaction-level model.
module tb_dram_arbiter;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  we = '0;
  logic [63:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [7:0]  dram_in = '0;
  logic [3:0]  o_ack;
  logic [7:0]  o_rdata;
  logic [3:0]  o_grant;
  logic        o_busy;
  logic [15:0] o_dram_addr;
  logic        o_dram_read;
  logic        o_dram_write;
  logic [7:0]  o_dram_out;

  int checks = 0;
  int failures = 0;
  int model_p = 0;
  logic [7:0] model_rdata = '0;

  dram_arbiter #(.RD_LAT(RD_LAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .o_ack(o_ack), .o_rdata(o_rdata), .o_grant(o_grant), .o_busy(o_busy),
    .o_dram_addr(o_dram_addr), .o_dram_read(o_dram_read), .o_dram_write(o_dram_write),
    .o_dram_out(o_dram_out), .i_dram_in(dram_in)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first requester at or above p, wrapping 3 -> 0; -1 when nobody asks.
  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic reset_dut;
    rst = 1'b1; req = '0; we = '0;
    tick; tick;
    rst = 1'b0;
    model_p = 0;
    model_rdata = '0;
  endtask

  // One transaction from an idle DUT: expected winner, strobes and ack timing come from the model.
  task automatic do_txn(input logic [3:0] r, input logic [3:0] w, input logic [63:0] a,
                        input logic [31:0] d, input logic [7:0] rdv, input bit scramble);
    int g, lat;
    logic ew, exp_rd, exp_wr;
    logic [15:0] ea;
    logic [7:0] ed;
    logic [3:0] oh;
    req = r; we = w; addr = a; wdata = d;
    g = rr_pick(r, model_p);
    if (g < 0) begin
      tick;
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL txn_noreq_busy got=%b exp=0", o_busy); end
      return;
    end
    ew = w[g]; ea = a[16*g +: 16]; ed = d[8*g +: 8]; oh = 4'b0001 << g;
    lat = ew ? 2 : RD_LAT + 2;
    model_p = (g + 1) % 4;
    for (int cyc = 1; cyc <= lat; cyc++) begin
      tick;
      if (scramble) begin
        req = 4'($urandom); we = 4'($urandom); addr = {$urandom, $urandom}; wdata = $urandom;
      end
      dram_in = (cyc == RD_LAT + 1) ? rdv : ~rdv;
      exp_rd = !ew && (cyc < lat);
      exp_wr = ew && (cyc == 1);
      checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL txn_busy cyc=%0d got=%b exp=1", cyc, o_busy); end
      checks++; if (o_grant !== oh) begin failures++; $display("FAIL txn_grant cyc=%0d got=%b exp=%b", cyc, o_grant, oh); end
      checks++; if ({o_dram_read, o_dram_write} !== {exp_rd, exp_wr}) begin failures++; $display("FAIL txn_strobes cyc=%0d got rd/wr=%b%b exp=%b%b", cyc, o_dram_read, o_dram_write, exp_rd, exp_wr); end
      checks++; if (o_ack !== ((cyc == lat) ? oh : 4'b0000)) begin failures++; $display("FAIL txn_ack cyc=%0d got=%b exp=%b", cyc, o_ack, (cyc == lat) ? oh : 4'b0000); end
      if (cyc == 1) begin
        checks++; if (o_dram_addr !== ea) begin failures++; $display("FAIL txn_addr got=%h exp=%h", o_dram_addr, ea); end
        checks++; if (o_dram_out !== ed) begin failures++; $display("FAIL txn_wdata got=%h exp=%h", o_dram_out, ed); end
      end
      if (cyc == lat) begin
        if (!ew) model_rdata = rdv;
        checks++; if (o_rdata !== model_rdata) begin failures++; $display("FAIL txn_rdata got=%h exp=%h", o_rdata, model_rdata); end
      end
    end
    req = '0;
    tick;
    checks++; if ({o_busy, o_grant} !== 5'b0) begin failures++; $display("FAIL txn_idle busy/grant got=%b%b exp=0", o_busy, o_grant); end
    checks++; if ({o_dram_addr, o_dram_out} !== {ea, ed}) begin failures++; $display("FAIL txn_idle_hold got=%h/%h exp=%h/%h", o_dram_addr, o_dram_out, ea, ed); end
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    checks++; if ({o_ack, o_grant, o_busy, o_dram_read, o_dram_write} !== 11'b0) begin failures++; $display("FAIL reset_async_ctrl got=%b exp=0", {o_ack, o_grant, o_busy, o_dram_read, o_dram_write}); end
    checks++; if ({o_rdata, o_dram_addr, o_dram_out} !== 32'b0) begin failures++; $display("FAIL reset_async_data got=%h exp=0", {o_rdata, o_dram_addr, o_dram_out}); end
    req = 4'hF;
    tick; tick;
    checks++; if ({o_busy, o_grant, o_ack} !== 9'b0) begin failures++; $display("FAIL reset_held got=%b exp=0 (req ignored in reset)", {o_busy, o_grant, o_ack}); end
    req = '0;
    rst = 1'b0;
    model_p = 0;
    model_rdata = '0;
  endtask

  task automatic test_single_write;
    reset_dut;
    do_txn(4'b0001, 4'b0001, 64'h0000_0000_0000_1234, 32'h0000_00A5, 8'h00, 1'b0);
  endtask

  task automatic test_single_read;
    do_txn(4'b0100, 4'b0000, 64'h0000_00FF_0000_0000, 32'h0, 8'h3C, 1'b0);
  endtask

  task automatic test_round_robin;
    int acks, budget, e;
    rst = 1'b1; req = 4'hF; we = 4'($urandom);
    tick; tick;
    rst = 1'b0; model_p = 0;
    acks = 0; budget = 0;
    while (acks < 5 && budget < 60) begin
      tick; budget++;
      checks++; if (o_busy ? !$onehot(o_grant) : (o_grant !== 4'b0)) begin failures++; $display("FAIL rr_grant_onehot got=%b busy=%b", o_grant, o_busy); end
      if (o_ack !== 4'b0) begin
        e = rr_pick(4'hF, model_p);
        checks++; if (o_ack !== (4'b0001 << e)) begin failures++; $display("FAIL rr_order ack#%0d got=%b exp=%b", acks, o_ack, 4'b0001 << e); end
        model_p = (e + 1) % 4;
        acks++;
      end
    end
    req = '0;
    checks++; if (acks != 5) begin failures++; $display("FAIL rr_timeout acks got=%0d exp=5", acks); end
    budget = 0;
    while (o_busy && budget < 10) begin tick; budget++; end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rr_idle_timeout busy got=%b exp=0", o_busy); end
    model_rdata = o_rdata;
  endtask

  task automatic test_drop_during_access;
    int budget;
    reset_dut;
    req = 4'b0010; we = 4'b0000; addr = 64'h0000_0000_BEEF_0000; wdata = $urandom;
    tick;
    checks++; if ({o_grant, o_dram_read} !== 5'b0010_1) begin failures++; $display("FAIL drop_access got grant/rd=%b/%b exp=0010/1", o_grant, o_dram_read); end
    checks++; if (o_dram_addr !== 16'hBEEF) begin failures++; $display("FAIL drop_addr got=%h exp=beef", o_dram_addr); end
    req = 4'b1011; we = 4'b1010; addr = {$urandom, $urandom};
    dram_in = 8'hA5;
    for (int cyc = 2; cyc <= RD_LAT + 2; cyc++) begin
      tick;
      dram_in = (cyc == RD_LAT + 1) ? 8'h5A : 8'hA5;
      checks++; if (o_ack !== ((cyc == RD_LAT + 2) ? 4'b0010 : 4'b0000)) begin failures++; $display("FAIL drop_ack cyc=%0d got=%b", cyc, o_ack); end
    end
    checks++; if (o_rdata !== 8'h5A) begin failures++; $display("FAIL drop_rdata got=%h exp=5a", o_rdata); end
    model_rdata = 8'h5A;
    tick; tick;
    checks++; if (o_grant !== (4'b0001 << rr_pick(4'b1011, 2))) begin failures++; $display("FAIL drop_next_grant got=%b exp=%b", o_grant, 4'b0001 << rr_pick(4'b1011, 2)); end
    req = '0;
    budget = 0;
    while (o_busy && budget < 10) begin tick; budget++; end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL drop_idle_timeout busy got=%b exp=0", o_busy); end
    model_p = 0;
  endtask

  task automatic test_reset_in_rdwait;
    int budget, acks;
    reset_dut;
    req = 4'b0100; we = 4'b0000; addr = {$urandom, $urandom};
    tick;
    req = '0;
    tick;
    checks++; if (o_dram_read !== 1'b1) begin failures++; $display("FAIL rst_rdwait_setup rd got=%b exp=1", o_dram_read); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({o_busy, o_grant, o_dram_read, o_dram_write} !== 7'b0) begin failures++; $display("FAIL rst_rdwait_immediate got=%b exp=0", {o_busy, o_grant, o_dram_read, o_dram_write}); end
    checks++; if ({o_dram_addr, o_dram_out, o_rdata} !== 32'b0) begin failures++; $display("FAIL rst_rdwait_data got=%h exp=0", {o_dram_addr, o_dram_out, o_rdata}); end
    acks = 0;
    for (int i = 0; i < 2; i++) begin
      tick;
      if (o_ack !== 4'b0) acks++;
    end
    req = 4'b1010; we = 4'b0010; wdata = $urandom;
    rst = 1'b0; model_p = 0; model_rdata = '0;
    tick;
    checks++; if (o_grant !== (4'b0001 << rr_pick(4'b1010, 0))) begin failures++; $display("FAIL rst_first_grant got=%b exp=%b", o_grant, 4'b0001 << rr_pick(4'b1010, 0)); end
    req = '0;
    budget = 0;
    while (o_busy && budget < 10) begin
      tick; budget++;
      if (o_ack !== 4'b0 && o_ack !== 4'b0010) acks++;
    end
    checks++; if (acks != 0) begin failures++; $display("FAIL rst_stale_ack count got=%0d exp=0", acks); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rst_idle_timeout busy got=%b exp=0", o_busy); end
    model_p = 2;
  endtask

  task automatic test_back_to_back;
    logic prev;
    req = 4'b1000; we = 4'b1000; addr = 64'hCAFE_0000_0000_0000; wdata = 32'h7700_0000;
    prev = 1'b0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      tick;
      checks++; if (o_dram_write !== ((cyc == 1) || (cyc == 4))) begin failures++; $display("FAIL b2b_write cyc=%0d got=%b", cyc, o_dram_write); end
      checks++; if (o_ack !== (((cyc == 2) || (cyc == 5)) ? 4'b1000 : 4'b0000)) begin failures++; $display("FAIL b2b_ack cyc=%0d got=%b", cyc, o_ack); end
      checks++; if (prev && o_dram_write) begin failures++; $display("FAIL b2b_overlap cyc=%0d got=1 exp=0", cyc); end
      prev = o_dram_write;
      if (cyc == 4) begin
        checks++; if ({o_dram_addr, o_dram_out} !== 24'hCAFE77) begin failures++; $display("FAIL b2b_payload got=%h exp=cafe77", {o_dram_addr, o_dram_out}); end
      end
    end
    req = '0;
    tick;
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL b2b_idle busy got=%b exp=0", o_busy); end
    model_p = 0;
  endtask

  task automatic test_random;
    logic [3:0] r;
    reset_dut;
    for (int i = 0; i < 40; i++) begin
      r = ($urandom_range(0, 7) == 0) ? 4'b0 : 4'($urandom);
      do_txn(r, 4'($urandom), {$urandom, $urandom}, $urandom, 8'($urandom), 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single_write;
    test_single_read;
    test_round_robin;
    test_drop_during_access;
    test_reset_in_rdwait;
    test_back_to_back;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
